// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_pkg
//  Purpose  : Shared widths and types for the architectural register file.
//  Revision : 1.0 - initial release
// ============================================================================
package reg_file_pkg;
  localparam int REG_NUM_WIDTH  = 5;
  localparam int ROB_SIZE_WIDTH = 5;
  localparam int REG_NUM        = 2 ** REG_NUM_WIDTH;
  localparam int XLEN           = 32;

  typedef logic [REG_NUM_WIDTH-1:0]  reg_idx_t;
  typedef logic [ROB_SIZE_WIDTH-1:0] rob_id_t;
  typedef logic [XLEN-1:0]           word_t;
endpackage
`default_nettype wire

// File: rtl/reg_file_if.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_if
//  Purpose  : Commit, flush, rename and operand-read bundle between the
//             ROB/decoder (master) and the register file (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface reg_file_if;
  import reg_file_pkg::*;

  // ROB commit and flush
  logic     rob2rf_ready;
  reg_idx_t rob2rf_rd;
  word_t    rob2rf_value;
  rob_id_t  rob2rf_rob_id;
  logic     rob_flush;

  // Decoder rename
  logic     dec_rename_valid;
  reg_idx_t dec_rename_rd;
  rob_id_t  dec_rename_rob_id;

  // Decoder operand reads
  reg_idx_t dec_rs1;
  reg_idx_t dec_rs2;
  word_t    rf2dec_val1;
  word_t    rf2dec_val2;
  logic     rf2dec_busy1;
  logic     rf2dec_busy2;
  rob_id_t  rf2dec_dep1;
  rob_id_t  rf2dec_dep2;

  modport master (
    output rob2rf_ready, rob2rf_rd, rob2rf_value, rob2rf_rob_id, rob_flush,
    output dec_rename_valid, dec_rename_rd, dec_rename_rob_id,
    output dec_rs1, dec_rs2,
    input  rf2dec_val1, rf2dec_val2, rf2dec_busy1, rf2dec_busy2,
    input  rf2dec_dep1, rf2dec_dep2
  );

  modport slave (
    input  rob2rf_ready, rob2rf_rd, rob2rf_value, rob2rf_rob_id, rob_flush,
    input  dec_rename_valid, dec_rename_rd, dec_rename_rob_id,
    input  dec_rs1, dec_rs2,
    output rf2dec_val1, rf2dec_val2, rf2dec_busy1, rf2dec_busy2,
    output rf2dec_dep1, rf2dec_dep2
  );
endinterface
`default_nettype wire

// File: rtl/reg_file_rf_read_port.sv
`default_nettype none
// ============================================================================
//  Module   : rf_read_port
//  Purpose  : One combinational operand read port: x0 masking, same-cycle
//             commit bypass, and pending-dependency reporting.
//  Revision : 1.0 - initial release
// ============================================================================
module rf_read_port
  import reg_file_pkg::*;
(
  input  reg_idx_t rs,
  input  word_t    ent_value,
  input  logic     ent_busy,
  input  rob_id_t  ent_dep,
  input  logic     cm_ready,
  input  reg_idx_t cm_rd,
  input  word_t    cm_value,
  input  rob_id_t  cm_rob_id,
  output word_t    val,
  output logic     busy,
  output rob_id_t  dep
);

  logic w_bypass;

  // A commit retiring exactly the producer we wait on satisfies the read now.
  assign w_bypass = ent_busy && cm_ready && (cm_rd == rs) && (cm_rob_id == ent_dep);

  // Priority: x0, bypass, pending, then stored value.
  always_comb begin
    val  = '0;
    busy = 1'b0;
    dep  = '0;
    if (rs != '0) begin
      if (w_bypass) begin
        val = cm_value;
      end else if (ent_busy) begin
        val  = ent_value;
        busy = 1'b1;
        dep  = ent_dep;
      end else begin
        val = ent_value;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file
//  Purpose  : 32 x 32-bit architectural register file with per-register
//             rename tags, ROB commit/flush handling and two read ports.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_file
  import reg_file_pkg::*;
(
  input  wire logic   clk_in,
  input  wire logic   rst_in,
  input  wire logic   rdy_in,
  reg_file_if.slave   bus
);

  logic [REG_NUM-1:0][XLEN-1:0]           value_q, value_d;
  logic [REG_NUM-1:0]                     busy_q,  busy_d;
  logic [REG_NUM-1:0][ROB_SIZE_WIDTH-1:0] dep_q,   dep_d;

  // Next state: commit writes value, flush clears tags, rename sets a tag.
  // The rename is applied last so it wins over a same-register commit.
  always_comb begin
    value_d = value_q;
    busy_d  = busy_q;
    dep_d   = dep_q;
    if (rdy_in) begin
      if (bus.rob2rf_ready && (bus.rob2rf_rd != '0)) begin
        value_d[bus.rob2rf_rd] = bus.rob2rf_value;
        // Only the youngest producer may clear the tag.
        if (busy_q[bus.rob2rf_rd] && (dep_q[bus.rob2rf_rd] == bus.rob2rf_rob_id)) begin
          busy_d[bus.rob2rf_rd] = 1'b0;
          dep_d[bus.rob2rf_rd]  = '0;
        end
      end
      if (bus.rob_flush) begin
        busy_d = '0;
        dep_d  = '0;
      end else if (bus.dec_rename_valid && (bus.dec_rename_rd != '0)) begin
        busy_d[bus.dec_rename_rd] = 1'b1;
        dep_d[bus.dec_rename_rd]  = bus.dec_rename_rob_id;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      value_q <= '0;
      busy_q  <= '0;
      dep_q   <= '0;
    end else begin
      value_q <= value_d;
      busy_q  <= busy_d;
      dep_q   <= dep_d;
    end
  end

  rf_read_port u_port1 (
    .rs        (bus.dec_rs1),
    .ent_value (value_q[bus.dec_rs1]),
    .ent_busy  (busy_q[bus.dec_rs1]),
    .ent_dep   (dep_q[bus.dec_rs1]),
    .cm_ready  (bus.rob2rf_ready),
    .cm_rd     (bus.rob2rf_rd),
    .cm_value  (bus.rob2rf_value),
    .cm_rob_id (bus.rob2rf_rob_id),
    .val       (bus.rf2dec_val1),
    .busy      (bus.rf2dec_busy1),
    .dep       (bus.rf2dec_dep1)
  );

  rf_read_port u_port2 (
    .rs        (bus.dec_rs2),
    .ent_value (value_q[bus.dec_rs2]),
    .ent_busy  (busy_q[bus.dec_rs2]),
    .ent_dep   (dep_q[bus.dec_rs2]),
    .cm_ready  (bus.rob2rf_ready),
    .cm_rd     (bus.rob2rf_rd),
    .cm_value  (bus.rob2rf_value),
    .cm_rob_id (bus.rob2rf_rob_id),
    .val       (bus.rf2dec_val2),
    .busy      (bus.rf2dec_busy2),
    .dep       (bus.rf2dec_dep2)
  );

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_file
//  Purpose  : Directed vector bench for reg_file.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file;
  import reg_file_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;

  reg_file_if bus ();

  reg_file dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic     rdy;
    logic     cm;
    reg_idx_t cm_rd;
    word_t    cm_val;
    rob_id_t  cm_id;
    logic     fl;
    logic     rn;
    reg_idx_t rn_rd;
    rob_id_t  rn_id;
    reg_idx_t rs1;
    reg_idx_t rs2;
    word_t    v1;
    logic     b1;
    rob_id_t  d1;
    word_t    v2;
    logic     b2;
    rob_id_t  d2;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(
    logic rdy_, logic cm_, int crd, word_t cval, int cid, logic fl_,
    logic rn_, int rrd, int rid, int r1, int r2,
    word_t v1_, logic b1_, int d1_, word_t v2_, logic b2_, int d2_);
    vec_t v;
    v.rdy = rdy_; v.cm = cm_; v.cm_rd = reg_idx_t'(crd); v.cm_val = cval;
    v.cm_id = rob_id_t'(cid); v.fl = fl_; v.rn = rn_; v.rn_rd = reg_idx_t'(rrd);
    v.rn_id = rob_id_t'(rid); v.rs1 = reg_idx_t'(r1); v.rs2 = reg_idx_t'(r2);
    v.v1 = v1_; v.b1 = b1_; v.d1 = rob_id_t'(d1_);
    v.v2 = v2_; v.b2 = b2_; v.d2 = rob_id_t'(d2_);
    return v;
  endfunction

  task automatic check(input string name, input int idx, input word_t act, input word_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rdy                   = v.rdy;
    bus.rob2rf_ready      = v.cm;
    bus.rob2rf_rd         = v.cm_rd;
    bus.rob2rf_value      = v.cm_val;
    bus.rob2rf_rob_id     = v.cm_id;
    bus.rob_flush         = v.fl;
    bus.dec_rename_valid  = v.rn;
    bus.dec_rename_rd     = v.rn_rd;
    bus.dec_rename_rob_id = v.rn_id;
    bus.dec_rs1           = v.rs1;
    bus.dec_rs2           = v.rs2;
  endtask

  task automatic check_ports(input vec_t v, input int idx);
    check("val1",  idx, bus.rf2dec_val1, v.v1);
    check("busy1", idx, word_t'(bus.rf2dec_busy1), word_t'(v.b1));
    check("dep1",  idx, word_t'(bus.rf2dec_dep1),  word_t'(v.d1));
    check("val2",  idx, bus.rf2dec_val2, v.v2);
    check("busy2", idx, word_t'(bus.rf2dec_busy2), word_t'(v.b2));
    check("dep2",  idx, word_t'(bus.rf2dec_dep2),  word_t'(v.d2));
  endtask

  initial begin
    // rdy cm rd val id fl rn rd id rs1 rs2 | v1 b1 d1 | v2 b2 d2
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,0, 5,0, 0,0,0, 0,0,0));                            // 0 reset state
    vecs.push_back(mk(1,0,0,0,0,0, 1,5,3, 5,0, 0,0,0, 0,0,0));                            // 1 rename x5->3, pre-rename read
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,0, 5,5, 0,1,3, 0,1,3));                            // 2 x5 pending on 3
    vecs.push_back(mk(1,1,5,32'hDEADBEEF,3,0, 0,0,0, 5,5, 32'hDEADBEEF,0,0, 32'hDEADBEEF,0,0)); // 3 bypass
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,0, 5,0, 32'hDEADBEEF,0,0, 0,0,0));                 // 4 stored
    vecs.push_back(mk(1,0,0,0,0,0, 1,7,2, 7,5, 0,0,0, 32'hDEADBEEF,0,0));                 // 5 rename x7->2
    vecs.push_back(mk(1,0,0,0,0,0, 1,7,9, 7,5, 0,1,2, 32'hDEADBEEF,0,0));                 // 6 rename x7->9
    vecs.push_back(mk(1,1,7,32'h11,2,0, 0,0,0, 7,0, 0,1,9, 0,0,0));                       // 7 stale commit, no bypass
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,0, 7,0, 32'h11,1,9, 0,0,0));                       // 8 value written, still busy
    vecs.push_back(mk(1,1,7,32'h22,9,0, 0,0,0, 7,0, 32'h22,0,0, 0,0,0));                  // 9 matching commit bypass
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,0, 7,0, 32'h22,0,0, 0,0,0));                       // 10 cleared
    vecs.push_back(mk(1,1,4,32'h5,1,0, 1,4,6, 4,0, 0,0,0, 0,0,0));                        // 11 commit+rename x4
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,0, 4,0, 32'h5,1,6, 0,0,0));                        // 12 rename wins
    vecs.push_back(mk(1,0,0,0,0,0, 1,1,4, 1,2, 0,0,0, 0,0,0));                            // 13 rename x1->4
    vecs.push_back(mk(1,0,0,0,0,0, 1,2,5, 1,2, 0,1,4, 0,0,0));                            // 14 rename x2->5
    vecs.push_back(mk(1,1,1,32'h80,4,1, 1,3,7, 1,2, 32'h80,0,0, 0,1,5));                  // 15 flush+commit+rename
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,0, 1,2, 32'h80,0,0, 0,0,0));                       // 16 flushed
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,0, 3,4, 0,0,0, 32'h5,0,0));                        // 17 x3 dropped, x4 cleared
    vecs.push_back(mk(1,1,0,32'hFFFF,8,0, 1,0,8, 0,0, 0,0,0, 0,0,0));                     // 18 x0 write/rename
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,0, 0,9, 0,0,0, 0,0,0));                            // 19 x0 still zero
    vecs.push_back(mk(0,1,9,32'h33,0,0, 0,0,0, 9,0, 0,0,0, 0,0,0));                       // 20 rdy low commit
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,0, 9,0, 0,0,0, 0,0,0));                            // 21 x9 unchanged
    vecs.push_back(mk(0,0,0,0,0,0, 1,9,3, 9,0, 0,0,0, 0,0,0));                            // 22 rdy low rename
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,0, 9,4, 0,0,0, 32'h5,0,0));                        // 23 x9 not renamed

    drive(mk(1,0,0,0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #2;
      check_ports(vecs[i], i);
      @(posedge clk);
      #1;
    end

    // Reset overrides a concurrent rename and commit.
    drive(mk(1,0,0,0,0,0, 1,6,2, 0,0, 0,0,0, 0,0,0));
    @(posedge clk); #1;
    drive(mk(1,1,5,32'h77,0,0, 1,6,4, 0,0, 0,0,0, 0,0,0));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(mk(1,0,0,0,0,0, 0,0,0, 5,6, 0,0,0, 0,0,0));
    #2;
    check_ports(mk(1,0,0,0,0,0, 0,0,0, 5,6, 0,0,0, 0,0,0), 100);

    // Bypass must not fire for a commit to a different register.
    drive(mk(1,0,0,0,0,0, 1,8,3, 0,0, 0,0,0, 0,0,0));
    @(posedge clk); #1;
    drive(mk(1,1,10,32'hAB,3,0, 0,0,0, 8,10, 0,0,0, 0,0,0));
    #2;
    check_ports(mk(1,0,0,0,0,0, 0,0,0, 8,10, 0,1,3, 0,0,0), 101);
    @(posedge clk); #1;
    drive(mk(1,0,0,0,0,0, 0,0,0, 8,10, 0,0,0, 0,0,0));
    #2;
    check_ports(mk(1,0,0,0,0,0, 0,0,0, 8,10, 0,1,3, 32'hAB,0,0), 102);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file with per-register rename tags, 32 x 32-bit.
- Receiving end of the ROB commit interface (rob2rf_rd/value/rob_id/ready) and of the ROB flush signal.
- Serves the decoder with two combinational operand read ports that return a value or a pending ROB dependency.
- Accepts one rename (rd -> ROB id) per cycle from the decoder.

Parameters:
- REG_NUM_WIDTH, 5, register index width (`REG_NUM_WIDTH); 2**REG_NUM_WIDTH registers.
- ROB_SIZE_WIDTH, 5, ROB entry id width (`ROB_SIZE_WIDTH).

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  synchronous active-high reset.
- rdy_in  input  1  global enable; low = hold all state.
- rob2rf_ready  input  1  commit strobe; every cycle it is high is one commit.
- rob2rf_rd  input  REG_NUM_WIDTH  commit destination register.
- rob2rf_value  input  32  commit value.
- rob2rf_rob_id  input  ROB_SIZE_WIDTH  ROB id of the committing entry.
- rob_flush  input  1  ROB need_flush_out; clears all rename tags.
- dec_rename_valid  input  1  decoder allocates rd to a ROB entry.
- dec_rename_rd  input  REG_NUM_WIDTH  renamed register.
- dec_rename_rob_id  input  ROB_SIZE_WIDTH  allocated ROB id.
- dec_rs1, dec_rs2  input  REG_NUM_WIDTH  read addresses.
- rf2dec_val1, rf2dec_val2  output  32  operand value; valid when busy is 0.
- rf2dec_busy1, rf2dec_busy2  output  1  operand pending in the ROB.
- rf2dec_dep1, rf2dec_dep2  output  ROB_SIZE_WIDTH  pending ROB id; 0 when not busy.

Behaviour:
- State per register: value[31:0], busy, dep[ROB_SIZE_WIDTH-1:0].
- Reset (rst_in high at posedge): all value = 0, busy = 0, dep = 0. Read outputs are combinational, so they read 0/0/0 after reset. Reset overrides everything, including mid-operation commits and renames.
- rdy_in low: no state change; reads remain live.
- Commit (rob2rf_ready, rd != 0):
  - value[rd] <= rob2rf_value unconditionally.
  - busy[rd] is cleared (and dep to 0) only if busy[rd] && dep[rd] == rob2rf_rob_id. A younger rename stays pending.
- Rename (dec_rename_valid, rd != 0, no flush): busy[rd] <= 1, dep[rd] <= dec_rename_rob_id.
- Commit and rename to the same rd in one cycle: value is written and the rename wins (busy = 1, dep = new id), whatever the tag match.
- Flush (rob_flush high):
  - All busy <= 0 and all dep <= 0.
  - A commit in the same cycle still writes its value (the JALR commit accompanies flush).
  - A rename in the same cycle is dropped.
- x0: writes and renames are ignored; always reads value 0, busy 0, dep 0.
- Read port (combinational, per port), in priority order:
  - rs == 0 -> 0/0/0.
  - busy[rs] && rob2rf_ready && rob2rf_rd == rs && rob2rf_rob_id == dep[rs] -> bypass: val = rob2rf_value, busy 0, dep 0.
  - busy[rs] -> val = value[rs] (don't care), busy 1, dep = dep[rs].
  - otherwise val = value[rs], busy 0, dep 0.
- Reads see pre-rename state. A same-cycle rename by the decoder is not reflected, so an instruction's sources never depend on its own rd. The decoder must not rename while rdy_in is low or while the ROB is full.
- Latency: commits and renames are visible on the read ports the cycle after the edge; the commit bypass covers the commit cycle itself.

Decomposition:
- const_param.v: REG_NUM_WIDTH, ROB_SIZE_WIDTH, REG_NUM.
- Sub-module rf_read_port: combinational bypass/priority logic, instantiated twice (rs1, rs2). The storage and update logic stay in reg_file.

Test Plan:
- Reset, then read rs1=5, rs2=0 -> val 0, busy 0, dep 0 on both ports.
- Rename x5->id 3; next cycle read x5 -> busy1=1, dep1=3. Commit rd=5, id=3, value 0xDEADBEEF -> same-cycle read gives val 0xDEADBEEF, busy 0 (bypass). Next cycle: stored value 0xDEADBEEF, busy 0.
- Rename x7->id 2, then x7->id 9; commit rd=7, id=2, value 0x11 -> value[7]=0x11, x7 still busy with dep 9. Commit id 9, value 0x22 -> busy 0, value 0x22.
- Same cycle: commit rd=4 id=1 value 0x5 and rename x4->id 6 -> x4 busy, dep 6, value 0x5.
- Renames x1->4, x2->5 pending; flush together with commit rd=1 id=4 value 0x80 and rename x3->7 -> all busy 0, x1=0x80, x3 not busy.
- Rename x0->id 8 and commit rd=0 value 0xFFFF -> x0 reads 0, not busy. With rdy_in=0, commit rd=9 value 0x33 -> x9 unchanged.
